scarf_spi_frontend: RTL and testbench

SPI-side front end of the SCARF register bus: oversamples an external mode-0 SPI link (sclk, mosi, cs_n) in the clk domain and converts it to the byte-stream interface consumed by every SCARF register-map slave (data_in, data_in_valid, data_in_finished, slave_id, rnw). It also serialises the OR-combined slave read data (read_data_in) back onto miso. One instance per design; all regmap slaves hang off its outputs.

---
 rtl/scarf_pkg.sv | 22 ++
 rtl/scarf_sync.sv | 25 ++
 rtl/scarf_spi_frontend.sv | 199 +++++++++++++++++++
 tb/tb_scarf_spi_frontend.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scarf_pkg.sv
// Shared types and constants for the SCARF register-bus SPI front end.
// Imported by the synchroniser and the front-end top level.
package scarf_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned SLAVE_ID_W = 7;

    localparam logic [SLAVE_ID_W-1:0] SLAVE_ID_NONE = 7'h00;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ID_BYTE = 2'd1,
        DATA    = 2'd2
    } state_e;

    // MSB-first shift: new bit enters at the LSB.
    function automatic logic [BYTE_W-1:0] shift_in(input logic [BYTE_W-1:0] cur,
                                                   input logic              bit_in);
        return {cur[BYTE_W-2:0], bit_in};
    endfunction

endpackage

// File: rtl/scarf_sync.sv
// N-stage single-bit synchroniser for an asynchronous input into the clk domain.
// RESET_VAL sets the value the chain holds while in reset.
module scarf_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n_sync,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            chain_q <= {STAGES{RESET_VAL}};
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/scarf_spi_frontend.sv
// SPI mode-0 slave front end: oversamples sclk/mosi/cs_n in the clk domain, turns
// frames into the SCARF byte-stream interface and serialises slave read data onto miso.
module scarf_spi_frontend
    import scarf_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n_sync,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  cs_n,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [BYTE_W-1:0]     read_data_in,
    output logic [BYTE_W-1:0]     data_in,
    output logic                  data_in_valid,
    output logic                  data_in_finished,
    output logic [SLAVE_ID_W-1:0] slave_id,
    output logic                  rnw
);

    localparam int unsigned SETTLE_W = $clog2(SYNC_STAGES + 1);

    logic sclk_s;
    logic mosi_s;
    logic cs_n_s;

    scarf_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sync_sclk (
        .clk        (clk),
        .rst_n_sync (rst_n_sync),
        .d          (sclk),
        .q          (sclk_s)
    );

    scarf_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sync_mosi (
        .clk        (clk),
        .rst_n_sync (rst_n_sync),
        .d          (mosi),
        .q          (mosi_s)
    );

    scarf_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync_cs_n (
        .clk        (clk),
        .rst_n_sync (rst_n_sync),
        .d          (cs_n),
        .q          (cs_n_s)
    );

    // Edge detection on the synchronised pins.
    logic                sclk_q;
    logic                cs_n_q;
    logic [SETTLE_W-1:0] settle_q;
    logic                settled;
    logic                sclk_rise;
    logic                sclk_fall;
    logic                cs_rise;
    logic                cs_fall;

    assign settled = (settle_q == SETTLE_W'(SYNC_STAGES));

    // Until the chains hold real pin samples, cs_n is treated as already low so a frame
    // in flight at reset release produces no fall; it is only picked up after a rise.
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            settle_q <= '0;
            sclk_q   <= 1'b0;
            cs_n_q   <= 1'b0;
        end else begin
            if (!settled) begin
                settle_q <= settle_q + 1'b1;
            end
            sclk_q <= sclk_s;
            cs_n_q <= settled ? cs_n_s : 1'b0;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign cs_fall   = settled & cs_n_q & ~cs_n_s;
    assign cs_rise   = settled & ~cs_n_q & cs_n_s;

    // Frame state and datapath.
    state_e                state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]     rx_q, rx_d;
    logic [BYTE_W-1:0]     tx_q, tx_d;
    logic                  load_pend_q, load_pend_d;
    logic [BYTE_W-1:0]     data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  fin_q, fin_d;
    logic [SLAVE_ID_W-1:0] sid_q, sid_d;
    logic                  rnw_q, rnw_d;
    logic [BYTE_W-1:0]     rx_shift;

    assign rx_shift = shift_in(rx_q, mosi_s);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        load_pend_d = load_pend_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        fin_d       = 1'b0;
        sid_d       = sid_q;
        rnw_d       = rnw_q;

        // Frame target stays visible through the finished pulse, then drops.
        if (fin_q) begin
            sid_d = SLAVE_ID_NONE;
            rnw_d = 1'b0;
        end

        // cs_n rise takes priority over a byte completing in the same cycle.
        if (cs_rise) begin
            fin_d       = (state_q != IDLE);
            state_d     = IDLE;
            bit_cnt_d   = '0;
            rx_d        = '0;
            tx_d        = '0;
            load_pend_d = 1'b0;
        end else if (cs_fall) begin
            state_d     = ID_BYTE;
            bit_cnt_d   = '0;
            rx_d        = '0;
            tx_d        = '0;
            load_pend_d = 1'b0;
        end else if (state_q != IDLE) begin
            if (sclk_rise) begin
                rx_d      = rx_shift;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    load_pend_d = 1'b1;
                    if (state_q == ID_BYTE) begin
                        sid_d   = rx_shift[SLAVE_ID_W-1:0];
                        rnw_d   = rx_shift[BYTE_W-1];
                        state_d = DATA;
                    end else begin
                        data_d  = rx_shift;
                        valid_d = 1'b1;
                    end
                end
            end else if (sclk_fall) begin
                if (load_pend_q) begin
                    tx_d        = read_data_in;
                    load_pend_d = 1'b0;
                end else begin
                    tx_d = shift_in(tx_q, 1'b0);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            load_pend_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            fin_q       <= 1'b0;
            sid_q       <= SLAVE_ID_NONE;
            rnw_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            load_pend_q <= load_pend_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            fin_q       <= fin_d;
            sid_q       <= sid_d;
            rnw_q       <= rnw_d;
        end
    end

    assign miso             = tx_q[BYTE_W-1];
    assign miso_oe          = (state_q != IDLE);
    assign data_in          = data_q;
    assign data_in_valid    = valid_q;
    assign data_in_finished = fin_q;
    assign slave_id         = sid_q;
    assign rnw              = rnw_q;

endmodule

// File: tb/tb_scarf_spi_frontend.sv
// Self-checking bench for scarf_spi_frontend: pin-level SPI master, event-queue reference
// model compared every cycle, plus literal checks on directed frames.
module tb_scarf_spi_frontend;

    localparam int N = 2;
    localparam int K_VALID = 0;
    localparam int K_FIN   = 1;
    localparam int K_SID   = 2;
    localparam int K_MISO  = 3;
    localparam int K_OE    = 4;

    logic       clk = 1'b0;
    logic       rst_n_sync = 1'b0;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       cs_n = 1'b1;
    logic [7:0] read_data_in = 8'h00;
    logic       miso;
    logic       miso_oe;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_finished;
    logic [6:0] slave_id;
    logic       rnw;

    scarf_spi_frontend #(.SYNC_STAGES(N)) dut (
        .clk              (clk),
        .rst_n_sync       (rst_n_sync),
        .sclk             (sclk),
        .mosi             (mosi),
        .cs_n             (cs_n),
        .miso             (miso),
        .miso_oe          (miso_oe),
        .read_data_in     (read_data_in),
        .data_in          (data_in),
        .data_in_valid    (data_in_valid),
        .data_in_finished (data_in_finished),
        .slave_id         (slave_id),
        .rnw              (rnw)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    // Reference model: pin activity becomes timestamped output events.
    typedef struct {
        int cyc;
        int kind;
        int val;
    } ev_t;
    ev_t evq[$];

    bit         m_active = 0;
    bit         m_pend = 0;
    int         m_bit = 0;
    int         m_idx = 0;
    int         m_pos = -1;
    logic [7:0] m_rx = 8'h00;
    logic [7:0] m_rbyte = 8'h00;

    function automatic void push(input int dly, input int kind, input int val);
        ev_t e;
        e.cyc  = cyc + dly;
        e.kind = kind;
        e.val  = val;
        evq.push_back(e);
    endfunction

    // DUT observation log used by the literal checks.
    logic [7:0] vlog[$];
    int         fin_cnt = 0;
    int         oe_cnt = 0;
    logic [6:0] fin_sid = 7'h7f;
    logic       fin_rnw = 1'b0;

    initial begin
        logic       e_valid, e_fin, e_rnw, e_miso, e_oe;
        logic [7:0] e_data;
        logic [6:0] e_sid;
        ev_t        e;
        e_data = 8'h00; e_sid = 7'h00; e_rnw = 1'b0; e_miso = 1'b0; e_oe = 1'b0;
        forever begin
            @(negedge clk);
            e_valid = 1'b0;
            e_fin   = 1'b0;
            if (!rst_n_sync) begin
                evq.delete();
                e_data = 8'h00; e_sid = 7'h00; e_rnw = 1'b0; e_miso = 1'b0; e_oe = 1'b0;
            end else begin
                while (evq.size() > 0 && evq[0].cyc <= cyc) begin
                    e = evq.pop_front();
                    case (e.kind)
                        K_VALID: begin e_valid = 1'b1; e_data = e.val[7:0]; end
                        K_FIN:   e_fin = 1'b1;
                        K_SID:   begin e_sid = e.val[6:0]; e_rnw = e.val[7]; end
                        K_MISO:  e_miso = e.val[0];
                        default: e_oe = e.val[0];
                    endcase
                end
            end
            check("data_in_valid", data_in_valid, e_valid);
            check("data_in_finished", data_in_finished, e_fin);
            check("data_in", data_in, e_data);
            check("slave_id", slave_id, e_sid);
            check("rnw", rnw, e_rnw);
            check("miso", miso, e_miso);
            check("miso_oe", miso_oe, e_oe);
            if (data_in_valid === 1'b1) vlog.push_back(data_in);
            if (data_in_finished === 1'b1) begin
                fin_cnt++;
                fin_sid = slave_id;
                fin_rnw = rnw;
            end
            if (miso_oe === 1'b1) oe_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pin_cs(input logic v);
        if (cs_n && !v) begin
            m_active = 1; m_bit = 0; m_idx = 0; m_rx = 8'h00; m_pend = 0; m_pos = -1;
            push(N + 1, K_OE, 1);
            push(N + 1, K_MISO, 0);
        end else if (!cs_n && v && m_active) begin
            m_active = 0;
            push(N + 1, K_FIN, 0);
            push(N + 1, K_OE, 0);
            push(N + 1, K_MISO, 0);
            push(N + 2, K_SID, 0);
        end
        cs_n = v;
    endtask

    task automatic pin_sclk(input logic v);
        if (m_active && !sclk && v) begin
            m_rx = {m_rx[6:0], mosi};
            m_bit++;
            if (m_bit == 8) begin
                m_bit = 0;
                if (m_idx == 0) push(N + 1, K_SID, int'(m_rx));
                else push(N + 1, K_VALID, int'(m_rx));
                m_idx++;
                m_pend = 1;
            end
        end else if (m_active && sclk && !v) begin
            if (m_pend) begin
                m_rbyte = read_data_in;
                m_pos = 7;
                m_pend = 0;
            end else if (m_pos >= 0) begin
                m_pos--;
            end
            if (m_pos >= 0) push(N + 1, K_MISO, int'(m_rbyte[m_pos]));
            else push(N + 1, K_MISO, 0);
        end
        sclk = v;
    endtask

    task automatic xfer(input logic [7:0] b, input int nbits, input int h,
                        input logic [7:0] rd_next, output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = b[7-i];
            step(h);
            got[7-i] = miso;
            pin_sclk(1'b1);
            if (i == 7) read_data_in = rd_next;
            step(h);
            pin_sclk(1'b0);
        end
    endtask

    task automatic frame(input logic [7:0] fb[8], input int nb, input int part, input int h,
                         input logic [7:0] rd[8], output logic [7:0] got[8]);
        logic [7:0] g;
        for (int k = 0; k < 8; k++) got[k] = 8'h00;
        pin_cs(1'b0);
        step(h);
        for (int k = 0; k < nb; k++) begin
            xfer(fb[k], 8, h, rd[k], g);
            got[k] = g;
        end
        if (part > 0) xfer(fb[nb], part, h, 8'h00, g);
        step(h);
        pin_cs(1'b1);
        step(h + N + 4);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL timeout: bench did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] fb[8];
        logic [7:0] rd[8];
        logic [7:0] got[8];
        logic [7:0] g;
        int         v0, f0, o0, nb, part, h;

        step(5);
        check("reset data_in", data_in, 8'h00);
        check("reset slave_id", slave_id, 7'h00);
        check("reset miso_oe", miso_oe, 1'b0);
        check("reset miso", miso, 1'b0);
        rst_n_sync = 1'b1;
        step(8);

        // Write frame
        fb = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        rd = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        v0 = vlog.size(); f0 = fin_cnt;
        frame(fb, 4, 0, 4, rd, got);
        check("wr valid count", vlog.size() - v0, 3);
        check("wr byte0", vlog[v0], 8'h00);
        check("wr byte1", vlog[v0+1], 8'h13);
        check("wr byte2", vlog[v0+2], 8'h00);
        check("wr finished count", fin_cnt - f0, 1);
        check("wr slave_id at finish", fin_sid, 7'h01);
        check("wr rnw at finish", fin_rnw, 1'b0);
        check("wr slave_id after", slave_id, 7'h00);

        // Read frame with echoed address then register contents
        fb = '{8'h81, 8'h02, 8'h5A, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00};
        rd = '{8'h01, 8'hA5, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        v0 = vlog.size(); f0 = fin_cnt;
        frame(fb, 4, 0, 5, rd, got);
        check("rd miso byte0", got[0], 8'h00);
        check("rd miso byte1", got[1], 8'h01);
        check("rd miso byte2", got[2], 8'hA5);
        check("rd miso byte3", got[3], 8'h3C);
        check("rd rnw at finish", fin_rnw, 1'b1);
        check("rd valid count", vlog.size() - v0, 3);
        check("rd rnw after", rnw, 1'b0);

        // Partial trailing byte is discarded
        fb = '{8'h01, 8'h00, 8'h13, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        v0 = vlog.size(); f0 = fin_cnt;
        frame(fb, 3, 5, 4, rd, got);
        check("partial valid count", vlog.size() - v0, 2);
        check("partial finished count", fin_cnt - f0, 1);
        check("partial data_in kept", data_in, 8'h13);

        // ID byte only
        fb = '{8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        v0 = vlog.size(); f0 = fin_cnt;
        frame(fb, 1, 0, 4, rd, got);
        check("id-only valid count", vlog.size() - v0, 0);
        check("id-only finished count", fin_cnt - f0, 1);
        check("id-only slave_id at finish", fin_sid, 7'h01);
        check("id-only slave_id after", slave_id, 7'h00);

        // Reset in the middle of byte 1
        pin_cs(1'b0);
        step(4);
        xfer(8'h01, 8, 4, 8'h00, g);
        xfer(8'h55, 4, 4, 8'h00, g);
        rst_n_sync = 1'b0;
        m_active = 0; m_pend = 0; m_pos = -1;
        step(3);
        check("midrst data_in", data_in, 8'h00);
        check("midrst slave_id", slave_id, 7'h00);
        check("midrst miso_oe", miso_oe, 1'b0);
        rst_n_sync = 1'b1;
        step(8);
        f0 = fin_cnt;
        pin_cs(1'b1);
        step(10);
        check("stale frame finished count", fin_cnt - f0, 0);
        fb = '{8'h02, 8'h05, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        v0 = vlog.size(); f0 = fin_cnt;
        frame(fb, 3, 0, 4, rd, got);
        check("post-reset valid count", vlog.size() - v0, 2);
        check("post-reset byte0", vlog[v0], 8'h05);
        check("post-reset byte1", vlog[v0+1], 8'hAA);
        check("post-reset slave_id at finish", fin_sid, 7'h02);

        // sclk activity with cs_n high
        v0 = vlog.size(); f0 = fin_cnt; o0 = oe_cnt;
        for (int i = 0; i < 16; i++) begin
            pin_sclk(1'b1);
            step(3);
            pin_sclk(1'b0);
            step(3);
        end
        step(6);
        check("idle sclk valid count", vlog.size() - v0, 0);
        check("idle sclk finished count", fin_cnt - f0, 0);
        check("idle sclk miso_oe cycles", oe_cnt - o0, 0);

        // cs_n rise together with the 8th sclk rise of a data byte
        v0 = vlog.size(); f0 = fin_cnt;
        pin_cs(1'b0);
        step(4);
        xfer(8'h01, 8, 4, 8'h00, g);
        xfer(8'h77, 7, 4, 8'h00, g);
        mosi = 1'b1;
        step(4);
        pin_cs(1'b1);
        pin_sclk(1'b1);
        step(8);
        pin_sclk(1'b0);
        step(8);
        check("cs-wins valid count", vlog.size() - v0, 0);
        check("cs-wins finished count", fin_cnt - f0, 1);

        // Randomised frames
        for (int f = 0; f < 30; f++) begin
            nb   = $urandom_range(0, 5);
            part = $urandom_range(0, 7);
            h    = $urandom_range(4, 7);
            for (int k = 0; k < 8; k++) begin
                fb[k] = 8'($urandom);
                rd[k] = 8'($urandom);
            end
            v0 = vlog.size(); f0 = fin_cnt;
            frame(fb, nb, part, h, rd, got);
            check("rand valid count", vlog.size() - v0, (nb > 0) ? nb - 1 : 0);
            check("rand finished count", fin_cnt - f0, 1);
        end

        step(4);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
